div_issue_ctrl: RTL
===================

Name: div_issue_ctrl

Overview:
Execute-stage requester for the shared divider unit. It accepts one decoded DIV/DIVU/REM/REMU(W) op at a time from the issue stage and drives the divider's valid_in/ready/valid/block handshake. It captures the quotient or remainder and presents it, with its destination tag, to the writeback arbiter. It also owns pipeline-flush handling and the RISC-V divide-by-zero and overflow corner cases.

Parameters:
XLEN, 64, operand/result width
TAG_W, 5, destination register tag width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  issue stage presents a div op
in_ready  out  1  controller can accept an op this cycle
in_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
in_is_w  in  1  32-bit W variant
in_src1  in  XLEN  dividend
in_src2  in  XLEN  divisor
in_rd  in  TAG_W  destination tag
flush  in  1  kill any op not yet handed to writeback
div_valid_in  out  1  request to divider
div_ready  in  1  divider accepts request
div_src1  out  XLEN  held dividend
div_src2  out  XLEN  held divisor
div_ctr  out  2  held op
div_is_w  out  1  held W flag
div_valid  in  1  divider result valid
div_result  in  XLEN  divider result
div_block  out  1  divider must hold its result
wb_valid  out  1  result available
wb_ready  in  1  writeback consumes result
wb_rd  out  TAG_W  destination tag
wb_data  out  XLEN  result
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; in_ready=1; div_valid_in=0; wb_valid=0; div_block=1; busy=0; all data registers 0.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - in_ready=1.
  - On in_valid && !flush, latch op, is_w, src1, src2 and rd.
  - Go to DONE if the special case applies (see Optional Feature); otherwise go to ISSUE.
- ISSUE:
  - div_valid_in=1, operands come from the held registers.
  - On div_ready, go to WAIT.
  - Handshake happens on the cycle where div_valid_in && div_ready, so minimum issue cost is 1 cycle.
- WAIT:
  - div_block=0; in every other state div_block=1.
  - On div_valid, capture div_result into wb_data and go to DONE.
  - The divider's own W sign-extension is trusted; no re-extension here.
- DONE:
  - wb_valid=1.
  - On wb_ready, go to IDLE.
  - No new op is accepted in the same cycle; in_ready stays 0 until back in IDLE.
- DRAIN:
  - div_block=0.
  - On div_valid, discard the result and go to IDLE.
- Latency: at least 3 cycles from accept to wb_valid (IDLE, then ISSUE, then WAIT with div_valid), plus the divider's latency.
- Flush rules; flush takes priority over every other transition:
  - IDLE: no accept.
  - ISSUE with div_ready in the same cycle: go to DRAIN (request is already in the divider).
  - ISSUE without div_ready: go to IDLE.
  - WAIT without div_valid: go to DRAIN.
  - WAIT with div_valid: go to IDLE, result dropped.
  - DONE: go to IDLE; wb_valid drops the next cycle.
  - DRAIN: stay in DRAIN.
- wb_rd, wb_data and the div_* operand outputs stay stable while their valid signal is asserted.

Optional Feature:
- DIV_SPECIAL_BYPASS_EN defined: in IDLE the controller detects special cases at accept time, over the operand width selected by is_w. It skips the divider and goes straight to DONE with:
  - Divisor 0: quotient is all ones (-1), remainder is the dividend.
  - Signed overflow (dividend is the most-negative value, divisor is -1): quotient is the dividend, remainder is 0.
  - W results are sign-extended from bit 31.
- Undefined: every op goes through ISSUE; corner-case results come from the divider.

Decomposition:
- Shared package holds:
  - State enum.
  - Op encodings DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU.
  - XLEN.
- Natural sub-module: div_special_detect, a combinational block that takes op, is_w, src1 and src2 and produces a hit flag and the result. It is instantiated only under DIV_SPECIAL_BYPASS_EN.

Test Plan:
- DIV 100/7, divider model latency 4, wb_ready=1 -> div_valid_in 1 cycle after accept; wb_valid with wb_data=14 and correct wb_rd; back in IDLE the following cycle.
- REMU 100%7 with wb_ready held 0 for 5 cycles -> wb_valid stays high; wb_data=2 stays stable; in_ready=0 throughout.
- div_ready low for 3 cycles in ISSUE -> div_valid_in and operands held constant; exactly one divider handshake.
- Flush 1 cycle after handshake, divider responds 4 cycles later -> DRAIN, result discarded, wb_valid never asserted; next op accepted afterwards.
- With DIV_SPECIAL_BYPASS_EN: DIVW src1=5, src2=0 -> wb_data=0xFFFF_FFFF_FFFF_FFFF, no div_valid_in. DIV src1=0x8000_0000_0000_0000, src2=-1 -> wb_data=src1. REM on the same operands -> 0.
- rst asserted during WAIT -> next cycle state IDLE, wb_valid=0, div_block=1, in_ready=1.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: shared types and constants for the divider issue controller.
//   DIV_XLEN     : default operand/result width
//   div_state_e  : controller FSM states
//   DIV_OP_*     : 2-bit op encodings (bit 1 selects remainder, bit 0 unsigned)
package div_issue_ctrl_pkg;

  localparam int DIV_XLEN = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } div_state_e;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

endpackage

// File: rtl/div_issue_ctrl_special_detect.sv
// div_special_detect: combinational detection of RISC-V divide corner cases.
//   op_i, is_w_i     : operation and 32-bit W variant
//   src1_i, src2_i   : dividend, divisor
//   hit_o            : divide-by-zero or signed overflow detected
//   result_o         : architectural result for the detected case
// Only instantiated when DIV_SPECIAL_BYPASS_EN is defined.
module div_special_detect
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN = DIV_XLEN
) (
  input  logic [1:0]      op_i,
  input  logic            is_w_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            hit_o,
  output logic [XLEN-1:0] result_o
);

  logic [31:0]     a32, b32;
  logic            signed_op, rem_op, zero, ovf;
  logic [XLEN-1:0] dividend, min_neg;

  assign a32       = src1_i[31:0];
  assign b32       = src2_i[31:0];
  assign signed_op = (op_i == DIV_OP_DIV) || (op_i == DIV_OP_REM);
  assign rem_op    = op_i[1];
  assign min_neg   = {1'b1, {(XLEN-1){1'b0}}};

  // W variants operate on the low word and sign-extend from bit 31
  assign dividend = is_w_i ? {{(XLEN-32){a32[31]}}, a32} : src1_i;
  assign zero     = is_w_i ? (b32 == 32'd0) : (src2_i == '0);
  assign ovf      = signed_op &&
                    (is_w_i ? ((a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF))
                            : ((src1_i == min_neg) && (src2_i == '1)));

  assign hit_o = zero || ovf;

  // zero: q = -1, r = dividend; overflow: q = dividend, r = 0
  always_comb begin
    result_o = '0;
    if (zero)        result_o = rem_op ? dividend : '1;
    else if (ovf)    result_o = rem_op ? '0 : dividend;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: execute-stage requester for the shared divider.
//   Issue side : in_valid/in_ready, in_op, in_is_w, in_src1, in_src2, in_rd
//   Divider    : div_valid_in/div_ready request, div_src1/2, div_ctr, div_is_w,
//                div_valid/div_result response, div_block hold request
//   Writeback  : wb_valid/wb_ready, wb_rd, wb_data
//   Control    : flush kills any op not yet handed to writeback; busy = !IDLE
// Optional: define DIV_SPECIAL_BYPASS_EN to resolve divide-by-zero and signed
// overflow at accept time without using the divider.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_is_w,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_rd,
  input  logic             flush,
  output logic             div_valid_in,
  input  logic             div_ready,
  output logic [XLEN-1:0]  div_src1,
  output logic [XLEN-1:0]  div_src2,
  output logic [1:0]       div_ctr,
  output logic             div_is_w,
  input  logic             div_valid,
  input  logic [XLEN-1:0]  div_result,
  output logic             div_block,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             busy
);

  div_state_e       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             is_w_q, is_w_d;
  logic [XLEN-1:0]  src1_q, src1_d, src2_q, src2_d, wb_data_q, wb_data_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic             spec_hit;
  logic [XLEN-1:0]  spec_result;

`ifdef DIV_SPECIAL_BYPASS_EN
  div_special_detect #(.XLEN(XLEN)) u_special (
    .op_i     (in_op),
    .is_w_i   (in_is_w),
    .src1_i   (in_src1),
    .src2_i   (in_src2),
    .hit_o    (spec_hit),
    .result_o (spec_result)
  );
`else
  assign spec_hit    = 1'b0;
  assign spec_result = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      is_w_q    <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      is_w_q    <= is_w_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Flush is evaluated first in every state so it overrides all handshakes.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    is_w_d       = is_w_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    rd_d         = rd_q;
    wb_data_d    = wb_data_q;
    in_ready     = 1'b0;
    div_valid_in = 1'b0;
    div_block    = 1'b1;
    wb_valid     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          op_d   = in_op;
          is_w_d = in_is_w;
          src1_d = in_src1;
          src2_d = in_src2;
          rd_d   = in_rd;
          if (spec_hit) begin
            wb_data_d = spec_result;
            state_d   = S_DONE;
          end else begin
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        div_valid_in = 1'b1;
        // a request accepted in the flush cycle is already inside the divider
        if (flush)          state_d = div_ready ? S_DRAIN : S_IDLE;
        else if (div_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        div_block = 1'b0;
        if (flush) begin
          state_d = div_valid ? S_IDLE : S_DRAIN;
        end else if (div_valid) begin
          wb_data_d = div_result;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        wb_valid = 1'b1;
        if (flush || wb_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        div_block = 1'b0;
        if (!flush && div_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign div_src1 = src1_q;
  assign div_src2 = src2_q;
  assign div_ctr  = op_q;
  assign div_is_w = is_w_q;
  assign wb_rd    = rd_q;
  assign wb_data  = wb_data_q;
  assign busy     = (state_q != S_IDLE);

endmodule
